// File: rtl/iob_cfg_pkg.sv
// rtl/iob_cfg_pkg.sv - shared types and constants for the ioblock16 configuration loader
package iob_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_COMMIT = 3'd2,
        ST_DONE   = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

    // TSMUX encodings: any value with bit 1 set drives the pad
    localparam logic [1:0] TS_Z    = 2'b00;
    localparam logic [1:0] TS_CTRL = 2'b01;
    localparam logic [1:0] TS_DRV  = 2'b10;

    localparam int CFG_W          = 3;
    localparam int CFG_DORREG_BIT = 0;
    localparam int CFG_TSMUX_LSB  = 1;

endpackage

// File: rtl/iob_cfg_shadow.sv
// rtl/iob_cfg_shadow.sv - per-pad shadow register file with atomic commit to the active buses
module iob_cfg_shadow
    import iob_cfg_pkg::*;
#(
    parameter int NUM_IOB = 16,
    parameter int IDX_W   = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_wr_en,
    input  logic [IDX_W-1:0]     i_wr_idx,
    input  logic [CFG_W-1:0]     i_wr_data,
    input  logic                 i_commit,
    output logic [2*NUM_IOB-1:0] o_tsmux_bus,
    output logic [NUM_IOB-1:0]   o_dorreg_bus
);

    logic [CFG_W-1:0]     r_shadow [NUM_IOB];
    logic [2*NUM_IOB-1:0] r_tsmux;
    logic [NUM_IOB-1:0]   r_dorreg;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_IOB; i++) begin
                r_shadow[i] <= '0;
            end
        end else if (i_wr_en) begin
            r_shadow[i_wr_idx] <= i_wr_data;
        end
    end

    // All pads switch on the same edge so the ring never sees a mixed config
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tsmux  <= {NUM_IOB{TS_Z}};
            r_dorreg <= '0;
        end else if (i_commit) begin
            for (int i = 0; i < NUM_IOB; i++) begin
                r_tsmux[2*i +: 2] <= r_shadow[i][CFG_TSMUX_LSB +: 2];
                r_dorreg[i]       <= r_shadow[i][CFG_DORREG_BIT];
            end
        end
    end

    assign o_tsmux_bus  = r_tsmux;
    assign o_dorreg_bus = r_dorreg;

endmodule

// File: rtl/iob_config_loader.sv
// rtl/iob_config_loader.sv - load/commit sequencer for the pad config bank
// Optional IOCFG_PARITY_EN adds CFG_PAR and aborts a load on an even-parity violation.
module iob_config_loader
    import iob_cfg_pkg::*;
#(
    parameter int NUM_IOB = 16,
    parameter int IDX_W   = 4
) (
    input  logic                 IOCLK,
    input  logic                 RSTN,
    input  logic                 CFG_START,
    input  logic                 CFG_VALID,
    input  logic [CFG_W-1:0]     CFG_DATA,
`ifdef IOCFG_PARITY_EN
    input  logic                 CFG_PAR,
`endif
    output logic                 CFG_READY,
    output logic                 CFG_DONE,
    output logic                 CFG_ERR,
    output logic [2*NUM_IOB-1:0] TSMUX_BUS,
    output logic [NUM_IOB-1:0]   DORREG_BUS,
    output logic                 IOB_EN
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_IOB - 1);

    state_t             r_state;
    state_t             w_next_state;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   w_idx_next;
    logic               r_iob_en;
    logic               w_wr_en;
    logic               w_commit;
    logic               w_par_err;

`ifdef IOCFG_PARITY_EN
    assign w_par_err = ^{CFG_DATA, CFG_PAR};
`else
    assign w_par_err = 1'b0;
`endif

    always_ff @(posedge IOCLK or negedge RSTN) begin
        if (!RSTN) begin
            r_state  <= ST_IDLE;
            r_idx    <= '0;
            r_iob_en <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_idx    <= w_idx_next;
            // Enable trails the commit by one cycle so pads see settled buses
            r_iob_en <= (r_state == ST_DONE) && !CFG_START;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_idx_next   = r_idx;
        w_wr_en      = 1'b0;
        w_commit     = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (CFG_START) begin
                    w_next_state = ST_LOAD;
                    w_idx_next   = '0;
                end
            end
            ST_LOAD: begin
                // A restart wins over a coincident data beat
                if (CFG_START) begin
                    w_idx_next = '0;
                end else if (CFG_VALID) begin
                    if (w_par_err) begin
                        w_next_state = ST_ERROR;
                    end else begin
                        w_wr_en = 1'b1;
                        if (r_idx == LAST_IDX) begin
                            w_next_state = ST_COMMIT;
                        end else begin
                            w_idx_next = r_idx + 1'b1;
                        end
                    end
                end
            end
            ST_COMMIT: begin
                w_commit     = 1'b1;
                w_next_state = ST_DONE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    iob_cfg_shadow #(
        .NUM_IOB (NUM_IOB),
        .IDX_W   (IDX_W)
    ) u_shadow (
        .i_clk        (IOCLK),
        .i_rst_n      (RSTN),
        .i_wr_en      (w_wr_en),
        .i_wr_idx     (r_idx),
        .i_wr_data    (CFG_DATA),
        .i_commit     (w_commit),
        .o_tsmux_bus  (TSMUX_BUS),
        .o_dorreg_bus (DORREG_BUS)
    );

    assign CFG_READY = (r_state == ST_LOAD);
    assign CFG_DONE  = (r_state == ST_DONE);
`ifdef IOCFG_PARITY_EN
    assign CFG_ERR   = (r_state == ST_ERROR);
`else
    assign CFG_ERR   = 1'b0;
`endif
    assign IOB_EN    = r_iob_en;

endmodule

// File: tb/tb_iob_config_loader.sv
// tb/tb_iob_config_loader.sv - randomized self-checking bench for iob_config_loader
module tb_iob_config_loader;

    localparam int N     = 16;
    localparam int IDX_W = 4;

    logic             IOCLK = 1'b0;
    logic             RSTN;
    logic             CFG_START;
    logic             CFG_VALID;
    logic [2:0]       CFG_DATA;
`ifdef IOCFG_PARITY_EN
    logic             CFG_PAR;
`endif
    logic             CFG_READY;
    logic             CFG_DONE;
    logic             CFG_ERR;
    logic [2*N-1:0]   TSMUX_BUS;
    logic [N-1:0]     DORREG_BUS;
    logic             IOB_EN;

    logic [3:0]       flags;
    assign flags = {CFG_READY, CFG_DONE, CFG_ERR, IOB_EN};

    int               n_vec = 0;
    int               n_err = 0;
    logic [2:0]       words [N];
    logic [2*N-1:0]   exp_ts;
    logic [N-1:0]     exp_dr;

    iob_config_loader #(.NUM_IOB(N), .IDX_W(IDX_W)) dut (
        .IOCLK      (IOCLK),
        .RSTN       (RSTN),
        .CFG_START  (CFG_START),
        .CFG_VALID  (CFG_VALID),
        .CFG_DATA   (CFG_DATA),
`ifdef IOCFG_PARITY_EN
        .CFG_PAR    (CFG_PAR),
`endif
        .CFG_READY  (CFG_READY),
        .CFG_DONE   (CFG_DONE),
        .CFG_ERR    (CFG_ERR),
        .TSMUX_BUS  (TSMUX_BUS),
        .DORREG_BUS (DORREG_BUS),
        .IOB_EN     (IOB_EN)
    );

    always #5 IOCLK = ~IOCLK;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    // Active config after a commit: pad i takes TSMUX from word bits [2:1], DORREG from bit 0
    task automatic model_commit();
        for (int i = 0; i < N; i++) begin
            exp_ts[2*i +: 2] = words[i][2:1];
            exp_dr[i]        = words[i][0];
        end
    endtask

    task automatic randomize_words();
        for (int i = 0; i < N; i++) words[i] = 3'($urandom);
    endtask

    task automatic drive_word(input logic [2:0] d);
        CFG_DATA = d;
`ifdef IOCFG_PARITY_EN
        CFG_PAR  = ^d;
`endif
    endtask

    // Called at a negedge; START is sampled on the following posedge
    task automatic pulse_start(input bit with_beat);
        CFG_START = 1'b1;
        CFG_VALID = with_beat;
        drive_word(3'($urandom));
        @(negedge IOCLK);
        CFG_START = 1'b0;
        CFG_VALID = 1'b0;
    endtask

    // Feeds words[0..count-1]; returns at the negedge after the last transfer
    task automatic load_words(input bit gaps, input int count);
        int  n = 0;
        int  cyc = 0;
        bit  v;
        while (n < count && cyc < 400) begin
            v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            CFG_VALID = v;
            drive_word(v ? words[n] : 3'($urandom));
            n_vec++;
            if (flags !== 4'b1000) begin
                n_err++;
                $display("FAIL load_flags: got %b expected %b (beat %0d)", flags, 4'b1000, n);
            end
            n_vec++;
            if (TSMUX_BUS !== exp_ts || DORREG_BUS !== exp_dr) begin
                n_err++;
                $display("FAIL load_buses_hold: got %h/%h expected %h/%h", TSMUX_BUS, DORREG_BUS, exp_ts, exp_dr);
            end
            @(negedge IOCLK);
            if (v) n++;
            cyc++;
        end
        CFG_VALID = 1'b0;
        n_vec++;
        if (cyc >= 400) begin
            n_err++;
            $display("FAIL load_timeout: got %0d transfers expected %0d", n, count);
        end
    endtask

    // Called in the COMMIT cycle
    task automatic finish_commit();
        n_vec++;
        if (flags !== 4'b0000 || TSMUX_BUS !== exp_ts || DORREG_BUS !== exp_dr) begin
            n_err++;
            $display("FAIL commit_cycle: got %b %h/%h expected %b %h/%h", flags, TSMUX_BUS, DORREG_BUS, 4'b0000, exp_ts, exp_dr);
        end
        model_commit();
        CFG_VALID = 1'b1;
        drive_word(3'($urandom));
        @(negedge IOCLK);
        n_vec++;
        if (flags !== 4'b0100 || TSMUX_BUS !== exp_ts || DORREG_BUS !== exp_dr) begin
            n_err++;
            $display("FAIL done_first: got %b %h/%h expected %b %h/%h", flags, TSMUX_BUS, DORREG_BUS, 4'b0100, exp_ts, exp_dr);
        end
        for (int k = 0; k < 2; k++) begin
            drive_word(3'($urandom));
            @(negedge IOCLK);
            n_vec++;
            if (flags !== 4'b0101 || TSMUX_BUS !== exp_ts || DORREG_BUS !== exp_dr) begin
                n_err++;
                $display("FAIL done_enabled: got %b %h/%h expected %b %h/%h", flags, TSMUX_BUS, DORREG_BUS, 4'b0101, exp_ts, exp_dr);
            end
        end
        CFG_VALID = 1'b0;
    endtask

    task automatic test_reset();
        RSTN = 1'b1; CFG_START = 1'b0; CFG_VALID = 1'b0; drive_word(3'b000);
        exp_ts = '0; exp_dr = '0;
        #2 RSTN = 1'b0;
        #1;
        n_vec++;
        if ({flags, TSMUX_BUS, DORREG_BUS} !== '0) begin
            n_err++;
            $display("FAIL reset_async: got %b %h/%h expected all zero", flags, TSMUX_BUS, DORREG_BUS);
        end
        repeat (3) @(negedge IOCLK);
        RSTN = 1'b1;
        CFG_VALID = 1'b1;
        @(negedge IOCLK);
        @(negedge IOCLK);
        n_vec++;
        if ({flags, TSMUX_BUS, DORREG_BUS} !== '0) begin
            n_err++;
            $display("FAIL reset_idle: got %b %h/%h expected all zero", flags, TSMUX_BUS, DORREG_BUS);
        end
        CFG_VALID = 1'b0;
    endtask

    task automatic test_full_load();
        for (int i = 0; i < N; i++) words[i] = (i % 2 == 0) ? 3'b011 : 3'b100;
        pulse_start(1'b0);
        load_words(1'b0, N);
        finish_commit();
        n_vec++;
        if (TSMUX_BUS !== 32'h9999_9999 || DORREG_BUS !== 16'h5555) begin
            n_err++;
            $display("FAIL full_load_pattern: got %h/%h expected 99999999/5555", TSMUX_BUS, DORREG_BUS);
        end
    endtask

    task automatic test_backpressure();
        for (int r = 0; r < 2; r++) begin
            randomize_words();
            pulse_start(1'b0);
            load_words(1'b1, N);
            finish_commit();
        end
    endtask

    task automatic test_restart();
        randomize_words();
        pulse_start(1'b0);
        load_words(1'b1, 7);
        randomize_words();
        n_vec++;
        if (flags !== 4'b1000) begin
            n_err++;
            $display("FAIL restart_pre: got %b expected %b", flags, 4'b1000);
        end
        pulse_start(1'b1);
        load_words(1'b1, N);
        finish_commit();
    endtask

    task automatic test_reload();
        randomize_words();
        pulse_start(1'b0);
        n_vec++;
        if (IOB_EN !== 1'b0 || CFG_DONE !== 1'b0) begin
            n_err++;
            $display("FAIL reload_disable: got en=%b done=%b expected 0/0", IOB_EN, CFG_DONE);
        end
        load_words(1'b0, N);
        finish_commit();
    endtask

`ifdef IOCFG_PARITY_EN
    task automatic test_parity();
        randomize_words();
        pulse_start(1'b0);
        load_words(1'b0, 5);
        CFG_VALID = 1'b1;
        CFG_DATA  = 3'($urandom);
        CFG_PAR   = ~^CFG_DATA;
        @(negedge IOCLK);
        CFG_VALID = 1'b0;
        for (int k = 0; k < 2; k++) begin
            n_vec++;
            if (flags !== 4'b0010 || TSMUX_BUS !== exp_ts || DORREG_BUS !== exp_dr) begin
                n_err++;
                $display("FAIL parity_error: got %b %h/%h expected %b %h/%h", flags, TSMUX_BUS, DORREG_BUS, 4'b0010, exp_ts, exp_dr);
            end
            @(negedge IOCLK);
        end
        randomize_words();
        pulse_start(1'b0);
        load_words(1'b1, N);
        finish_commit();
    endtask
`endif

    task automatic test_reset_midload();
        randomize_words();
        pulse_start(1'b0);
        load_words(1'b0, 5);
        #2 RSTN = 1'b0;
        #1;
        exp_ts = '0; exp_dr = '0;
        n_vec++;
        if ({flags, TSMUX_BUS, DORREG_BUS} !== '0) begin
            n_err++;
            $display("FAIL reset_midload: got %b %h/%h expected all zero", flags, TSMUX_BUS, DORREG_BUS);
        end
        @(negedge IOCLK);
        RSTN = 1'b1;
        @(negedge IOCLK);
        n_vec++;
        if (flags !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_release_idle: got %b expected %b", flags, 4'b0000);
        end
        randomize_words();
        pulse_start(1'b0);
        load_words(1'b1, N);
        finish_commit();
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_backpressure();
        test_restart();
        test_reload();
`ifdef IOCFG_PARITY_EN
        test_parity();
`endif
        test_reset_midload();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
